// File: rtl/sonar_ping_controller_pkg.sv
// Shared encodings for the sonar ping controller: FSM states, register map and
// CTRL/STATUS bit positions, plus the STATUS word packer.
package sonar_ping_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RESULT = 2'd1;
    localparam logic [1:0] ADDR_PINGS  = 2'd2;

    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_CONT    = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_TIMEOUT = 3;

    localparam logic [31:0] RESULT_TIMEOUT = 32'hFFFF_FFFF;

    function automatic logic [31:0] pack_status(input logic busy, input logic cont,
                                                input logic done, input logic timeout);
        logic [31:0] v;
        v               = '0;
        v[STAT_BUSY]    = busy;
        v[STAT_CONT]    = cont;
        v[STAT_DONE]    = done;
        v[STAT_TIMEOUT] = timeout;
        return v;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by single-cycle
// rise and fall pulses derived from the synchronized level.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/sonar_ping_controller.sv
// Memory-mapped ping sequencer for one ultrasonic ranger: trigger, echo wait,
// echo width measurement, timeout and holdoff, with CTRL/STATUS, RESULT and PINGS registers.
module sonar_ping_controller
    import sonar_ping_controller_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int HOLDOFF_CYCLES = 3000000,
    parameter int CNT_W          = 22
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        wren,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        trig_out,
    input  logic        echo_in,
    output logic        done_irq
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t            r_state;
    logic              r_trig;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_timer;
    logic [CNT_W-1:0]  r_width;
    logic [31:0]       r_result;
    logic [31:0]       r_pings;
    logic              r_cont;
    logic              r_done;
    logic              r_timeout;
    logic [31:0]       r_rdata;

    logic        w_echo_rise;
    logic        w_echo_fall;
    logic        w_wr_ctrl;
    logic        w_start_ok;
    logic        w_clear;
    logic        w_cont_nxt;
    logic        w_timer_exp;
    logic        w_end_ok;
    logic        w_end_to;
    logic        w_ping_end;
    logic        w_hold_done;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_to_nxt;
    logic [31:0] w_result_nxt;
    logic [31:0] w_pings_nxt;
    logic [31:0] w_rdata;
    logic        w_unused_wdata;

    sync_edge u_echo_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (echo_in),
        .o_rise  (w_echo_rise),
        .o_fall  (w_echo_fall)
    );

    assign w_wr_ctrl      = sel & wren & (addr == ADDR_CTRL);
    assign w_start_ok     = w_wr_ctrl & data_in[CTRL_START] & (r_state == ST_IDLE);
    assign w_clear        = w_wr_ctrl & data_in[CTRL_CLEAR];
    assign w_cont_nxt     = w_wr_ctrl ? data_in[CTRL_CONT] : r_cont;
    assign w_unused_wdata = ^data_in[31:3];

    // A fall landing exactly on the timeout edge is still a valid echo.
    assign w_timer_exp = (r_timer == TIMEOUT_LAST);
    assign w_end_ok    = (r_state == ST_MEASURE) & w_echo_fall;
    assign w_end_to    = w_timer_exp & ((r_state == ST_WAIT_RISE) |
                                        ((r_state == ST_MEASURE) & ~w_echo_fall));
    assign w_ping_end  = w_end_ok | w_end_to;
    assign w_hold_done = (r_state == ST_HOLDOFF) & (r_cnt == HOLD_LAST);

    // Post-edge view of every software-visible field, shared by the registers and the read port.
    assign w_busy_nxt   = w_start_ok |
                          ((r_state != ST_IDLE) & ~(w_hold_done & ~w_cont_nxt));
    assign w_done_nxt   = w_ping_end | (r_done & ~w_clear);
    assign w_to_nxt     = w_end_to | (r_timeout & ~w_clear);
    assign w_result_nxt = w_end_to ? RESULT_TIMEOUT :
                          w_end_ok ? 32'(r_width) : r_result;
    assign w_pings_nxt  = r_pings + 32'(w_ping_end);

    always_comb begin
        w_rdata = '0;
        case (addr)
            ADDR_CTRL:   w_rdata = pack_status(w_busy_nxt, w_cont_nxt, w_done_nxt, w_to_nxt);
            ADDR_RESULT: w_rdata = w_result_nxt;
            ADDR_PINGS:  w_rdata = w_pings_nxt;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_trig  <= 1'b0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_width <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_TRIG;
                        r_trig  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_TRIG: begin
                    if (r_cnt == TRIG_LAST) begin
                        r_state <= ST_WAIT_RISE;
                        r_trig  <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_WAIT_RISE: begin
                    r_timer <= r_timer + CNT_ONE;
                    if (w_end_to) begin
                        r_state <= ST_HOLDOFF;
                        r_cnt   <= '0;
                    end else if (w_echo_rise) begin
                        r_state <= ST_MEASURE;
                        r_width <= CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    r_timer <= r_timer + CNT_ONE;
                    r_width <= r_width + CNT_ONE;
                    if (w_ping_end) begin
                        r_state <= ST_HOLDOFF;
                        r_cnt   <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (w_hold_done) begin
                        if (w_cont_nxt) begin
                            r_state <= ST_TRIG;
                            r_trig  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
            r_pings   <= '0;
            r_rdata   <= '0;
        end else begin
            r_cont    <= w_cont_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_to_nxt;
            r_result  <= w_result_nxt;
            r_pings   <= w_pings_nxt;
            if (sel) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign data_out = r_rdata;
    assign trig_out = r_trig;
    assign done_irq = r_done;

endmodule
